// File: rtl/ter_rd_req.sv
// ter_rd_req: read-side requester for the TER interleaver buffer with a credit-managed output FIFO
//   Optional error checking is enabled with `define TER_RD_ERRCHK_EN.
//   clk, n_rst         : clock, synchronous active-low reset
//   start, m_len       : begin reading a complete block of m_len symbols
//   request            : registered read strobe, one symbol per high cycle
//   din_vld, din       : returned symbol, valid exactly one cycle after request
//   dout, dout_vld     : first-word-fall-through FIFO head
//   dout_rdy           : downstream accept; pop = dout_vld && dout_rdy
//   dout_sop, dout_eop : first / last symbol of the block
//   busy, err          : not idle; sticky protocol error (0 without TER_RD_ERRCHK_EN)
module ter_rd_req #(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  m_len,
    output logic              request,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              busy,
    output logic              err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W:0]     issued_q, issued_d, popped_q, popped_d, len_x;
    logic [CW-1:0]      pend_q, pend_d, cnt_q, cnt_d;
    logic [CW:0]        credit;
    logic [AW-1:0]      wp_q, rp_q;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic               request_q, request_d, wr, pop, acc_start;

    assign len_x     = {1'b0, len_q};
    // din_vld with nothing outstanding is never written, in either build
    assign wr        = din_vld && pend_q != '0;
    assign pop       = dout_vld && dout_rdy;
    assign acc_start = state_q == IDLE && start && m_len != '0;
    assign request   = request_q;
    assign busy      = state_q != IDLE;
    assign dout_vld  = cnt_q != '0;
    assign dout      = dout_vld ? mem_q[rp_q] : '0;
    assign dout_sop  = dout_vld && popped_q == '0;
    assign dout_eop  = dout_vld && popped_q == len_x - (LEN_W+1)'(1);
    // space already promised: stored symbols, in-flight reads and the strobe now on the wire
    assign credit    = (CW+1)'(cnt_q) + (CW+1)'(pend_q) + (CW+1)'(request_q);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        issued_d  = issued_q + (LEN_W+1)'(request_q);
        popped_d  = popped_q + (LEN_W+1)'(pop);
        pend_d    = pend_q + CW'(request_q) - CW'(wr);
        cnt_d     = cnt_q + CW'(wr) - CW'(pop);
        request_d = state_q == READ && issued_d < len_x && credit < (CW+1)'(FIFO_DEPTH);
        if (acc_start) begin
            state_d  = READ;
            len_d    = m_len;
            issued_d = '0;
            popped_d = '0;
            pend_d   = '0;
        end else if (state_q == READ && issued_d == len_x) begin
            state_d = DRAIN;
        end else if (state_q == DRAIN && pop && popped_d == len_x) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            request_q <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            popped_q  <= popped_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            request_q <= request_d;
            wp_q      <= wp_q + AW'(wr);
            rp_q      <= rp_q + AW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= din;
    end

`ifdef TER_RD_ERRCHK_EN
    logic err_q, err_d;

    assign err_d = (din_vld && pend_q == '0) || (start && busy) || (err_q && !acc_start);
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (!n_rst) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ter_rd_req.sv
// tb_ter_rd_req: scoreboard bench for ter_rd_req with a one-cycle-latency buffer model
module tb_ter_rd_req;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 13;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              n_rst, start, dout_rdy, spur_vld;
    logic [LEN_W-1:0]  m_len;
    logic              request, din_vld, dout_vld, dout_sop, dout_eop, busy, err;
    logic [DATA_W-1:0] din, dout;
    logic              mdl_vld = 1'b0;
    logic [DATA_W-1:0] mdl_d = '0;
    int                idx = 0;

    int passed = 0, total = 0;
    int n_req = 0, n_pop = 0;
    logic [DATA_W+1:0] sb[$];

    assign din_vld = mdl_vld | spur_vld;
    assign din     = mdl_d;

    ter_rd_req #(.DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .m_len(m_len), .request(request),
        .din_vld(din_vld), .din(din), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // buffer model: returns the symbol index of each request one cycle later
    initial forever begin
        @(posedge clk);
        mdl_vld <= request;
        if (start && !busy) idx <= 0;
        else if (request) begin
            mdl_d <= DATA_W'(idx);
            idx   <= idx + 1;
        end
    end

    // scoreboard: expectations pushed at an accepted start, compared at each pop
    initial forever begin
        @(negedge clk);
        if (!n_rst) begin
            sb.delete();
            n_req = 0;
            n_pop = 0;
        end else begin
            if (start && !busy && m_len != '0) begin
                sb.delete();
                n_req = 0;
                n_pop = 0;
                for (int i = 0; i < int'(m_len); i++)
                    sb.push_back({i == 0, i == int'(m_len) - 1, DATA_W'(i)});
            end
            if (request) begin
                n_req++;
                total++;
                if (n_req - n_pop > DEPTH) $display("FAIL credit: outstanding %0d limit %0d", n_req - n_pop, DEPTH);
                else passed++;
            end
            if (dout_vld && dout_rdy) begin
                total++;
                if (sb.size() == 0) $display("FAIL pop: unexpected beat dout=%0h", dout);
                else begin
                    logic [DATA_W+1:0] e;
                    e = sb.pop_front();
                    if ({dout_sop, dout_eop, dout} !== e)
                        $display("FAIL beat %0d: got sop=%b eop=%b d=%0h want sop=%b eop=%b d=%0h",
                                 n_pop, dout_sop, dout_eop, dout, e[DATA_W+1], e[DATA_W], e[DATA_W-1:0]);
                    else passed++;
                end
                n_pop++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int len);
        m_len = LEN_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        cyc = 0;
        while (busy && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({request, dout_vld, dout_sop, dout_eop, busy, err, dout} !== '0)
            $display("FAIL reset: outputs %0h want 0", {request, dout_vld, dout_sop, dout_eop, busy, err, dout});
        else passed++;
        n_rst = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || request !== 1'b0) $display("FAIL reset_idle: busy=%b request=%b want 0 0", busy, request);
        else passed++;
    endtask

    task automatic test_stream();
        int cyc;
        dout_rdy = 1'b1;
        kick(432);
        total++;
        if (busy !== 1'b1 || request !== 1'b0) $display("FAIL stream_c1: busy=%b request=%b want 1 0", busy, request);
        else passed++;
        tick();
        total++;
        if (request !== 1'b1) $display("FAIL stream_c2: request=%b want 1", request);
        else passed++;
        wait_idle(2000, cyc);
        total++;
        if (cyc + 2 != 436) $display("FAIL stream_busy: busy fell at cycle %0d want 436", cyc + 2);
        else passed++;
        total++;
        if (sb.size() != 0 || n_pop != 432) $display("FAIL stream_count: pops=%0d left=%0d want 432 0", n_pop, sb.size());
        else passed++;
    endtask

    task automatic test_len1();
        int cyc, nr;
        dout_rdy = 1'b1;
        kick(1);
        nr = 0;
        cyc = 0;
        while (busy && cyc < 50) begin
            if (request) nr++;
            tick();
            cyc++;
        end
        total++;
        if (nr != 1 || n_pop != 1 || sb.size() != 0) $display("FAIL len1: requests=%0d pops=%0d want 1 1", nr, n_pop);
        else passed++;
    endtask

    task automatic test_backpressure();
        int cyc, nr;
        dout_rdy = 1'b0;
        kick(16);
        nr = 0;
        repeat (30) begin
            if (request) nr++;
            tick();
        end
        total++;
        if (nr != 4 || request !== 1'b0) $display("FAIL bp_stall: requests=%0d request=%b want 4 0", nr, request);
        else passed++;
        total++;
        if (dout_vld !== 1'b1 || dout_sop !== 1'b1 || dout !== 8'h00)
            $display("FAIL bp_head: vld=%b sop=%b d=%0h want 1 1 0", dout_vld, dout_sop, dout);
        else passed++;
        dout_rdy = 1'b1;
        cyc = 0;
        while (busy && cyc < 200) begin
            if (request) nr++;
            tick();
            cyc++;
        end
        total++;
        if (nr != 16 || n_pop != 16 || sb.size() != 0) $display("FAIL bp_drain: requests=%0d pops=%0d want 16 16", nr, n_pop);
        else passed++;
    endtask

    task automatic test_random();
        int cyc;
        dout_rdy = 1'b0;
        kick(100);
        cyc = 0;
        while (busy && cyc < 3000) begin
            dout_rdy = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        dout_rdy = 1'b1;
        total++;
        if (busy !== 1'b0 || n_pop != 100 || sb.size() != 0) $display("FAIL random: busy=%b pops=%0d want 0 100", busy, n_pop);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        dout_rdy = 1'b1;
        kick(432);
        cyc = 0;
        while (n_pop < 50 && cyc < 500) begin
            tick();
            cyc++;
        end
        n_rst = 1'b0;
        tick();
        total++;
        if ({request, dout_vld, dout_sop, dout_eop, busy, err, dout} !== '0)
            $display("FAIL midrst: outputs %0h want 0", {request, dout_vld, dout_sop, dout_eop, busy, err, dout});
        else passed++;
        n_rst = 1'b1;
        repeat (3) tick();
        total++;
        if (dout_vld !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_drop: vld=%b busy=%b want 0 0", dout_vld, busy);
        else passed++;
        kick(12'h3cc);
        wait_idle(1500, cyc);
        total++;
        if (busy !== 1'b0 || n_pop != 972 || sb.size() != 0) $display("FAIL midrst_new: pops=%0d left=%0d want 972 0", n_pop, sb.size());
        else passed++;
    endtask

    task automatic test_err();
        int cyc;
        dout_rdy = 1'b1;
        spur_vld = 1'b1;
        tick();
        spur_vld = 1'b0;
        total++;
        if (dout_vld !== 1'b0) $display("FAIL spur_fifo: dout_vld=%b want 0", dout_vld);
        else passed++;
`ifdef TER_RD_ERRCHK_EN
        total++;
        if (err !== 1'b1) $display("FAIL spur_err: err=%b want 1", err);
        else passed++;
        kick(8);
        total++;
        if (err !== 1'b0) $display("FAIL err_clear: err=%b want 0", err);
        else passed++;
        kick(20);
        total++;
        if (err !== 1'b1) $display("FAIL start_busy: err=%b want 1", err);
        else passed++;
        wait_idle(100, cyc);
        total++;
        if (n_pop != 8 || sb.size() != 0) $display("FAIL start_ignored: pops=%0d want 8", n_pop);
        else passed++;
        kick(2);
        total++;
        if (err !== 1'b0) $display("FAIL err_clear2: err=%b want 0", err);
        else passed++;
        wait_idle(100, cyc);
`else
        total++;
        if (err !== 1'b0) $display("FAIL err_tied: err=%b want 0", err);
        else passed++;
        kick(3);
        wait_idle(100, cyc);
        total++;
        if (n_pop != 3 || sb.size() != 0 || err !== 1'b0) $display("FAIL after_spur: pops=%0d err=%b want 3 0", n_pop, err);
        else passed++;
`endif
    endtask

    initial begin
        n_rst    = 1'b0;
        start    = 1'b0;
        m_len    = '0;
        dout_rdy = 1'b0;
        spur_vld = 1'b0;
        test_reset();
        test_stream();
        test_len1();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_err();
        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
